register_file_stream_reader: RTL and testbench
==============================================

// Module: register_file_stream_reader
// PURPOSE
//  Read-side controller for the 16x16 latch register file: accepts a burst command (start, count),
//  drives the RF combinational read port, streams words out over valid/ready with a last flag.
//  Sits between the RF and the datapath consumer (e.g. LUT/accumulator); the RF write side is untouched.
// PARAMETERS
//  AddrWidth  4   RF address width; NumWords = 2**AddrWidth
//  DataWidth  16  RF word width
// PORTS
//  clk_i           in   1          clock
//  rst_ni          in   1          asynchronous active-low reset
//  cmd_valid_i     in   1          burst command valid
//  cmd_ready_o     out  1          command accepted when valid&ready
//  cmd_addr_i      in   AddrWidth  first word address
//  cmd_len_m1_i    in   AddrWidth  burst length minus one (1..NumWords words)
//  raddr_o         out  AddrWidth  RF read address (to raddr_a_i)
//  rdata_i         in   DataWidth  RF read data (combinational from raddr_o)
//  out_valid_o     out  1          stream word valid
//  out_ready_i     in   1          consumer ready
//  out_data_o      out  DataWidth  stream word
//  out_last_o      out  1          final word of burst
//  busy_o          out  1          burst in progress or output register occupied
//  stall_cnt_o     out  16         (RF_READER_STALL_CNT_EN only) stall cycle counter
// BEHAVIOUR
//  Reset: FSM=IDLE, cmd_ready_o=1, out_valid_o=0, out_data_o=0, out_last_o=0, raddr_o=0, busy_o=0, stall_cnt_o=0.
//  FSM IDLE: cmd_ready_o=1; on cmd_valid_i -> load addr_q=cmd_addr_i, rem_q=cmd_len_m1_i, go READ.
//  FSM READ: cmd_ready_o=0; raddr_o=addr_q; load fires when !out_valid_o | out_ready_i:
//   out_data_o<=rdata_i, out_valid_o<=1, out_last_o<=(rem_q==0); addr_q<=addr_q+1 (wraps mod NumWords);
//   rem_q<=rem_q-1; if rem_q==0 -> DRAIN.
//  FSM DRAIN: hold until last word handshakes (out_valid_o&out_ready_i&out_last_o) -> IDLE.
//  Last-word handshake and a new command may not overlap: next cmd accepted the cycle after return to IDLE.
//  Latency: first word valid 1 cycle after cmd accept; then 1 word/cycle while out_ready_i=1 (no bubbles).
//  Output stable: out_data_o/out_last_o must not change while out_valid_o=1 & out_ready_i=0.
//  out_valid_o deasserts on handshake when no new load occurs in the same cycle.
//  Wrap-around: cmd_addr_i=NumWords-1, len_m1=1 reads addr NumWords-1 then 0.
//  Full burst: len_m1=NumWords-1 reads every word exactly once.
//  raddr_o in IDLE/DRAIN holds last driven value (no spurious toggles).
//  Reset mid-burst: immediate return to reset values; partial burst discarded, no last emitted.
//  busy_o = (state!=IDLE) | out_valid_o.
// CONFIGURATION
//  RF_READER_STALL_CNT_EN defined: stall_cnt_o port present; increments (saturating at 16'hFFFF)
//   each cycle out_valid_o=1 & out_ready_i=0; cleared on cmd accept.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package register_file_pkg: default AddrWidth/DataWidth constants, typedef enum logic [1:0]
//   {RdIdle, RdRead, RdDrain} rd_state_e.
//  Single module, no sub-modules; output register inline (one-entry, pass-through ready).
// TESTING
//  1. addr=3, len_m1=3, out_ready=1 -> words mem[3..6] on 4 consecutive cycles, last on mem[6].
//  2. addr=15, len_m1=2 -> mem[15],mem[0],mem[1]; raddr_o sequence 15,0,1.
//  3. len_m1=15, out_ready toggling 1,0,1,0 -> all 16 words in order, data stable on stalls,
//     stall_cnt_o=8 with RF_READER_STALL_CNT_EN.
//  4. len_m1=0, addr=7 -> single word mem[7] with last=1, busy_o low one cycle after handshake.
//  5. cmd_valid held high during burst -> cmd_ready_o=0 until IDLE; second burst starts afterwards.
//  6. rst_ni low mid-burst (after 2 words) -> out_valid_o=0, cmd_ready_o=1 asynchronously; new cmd runs clean.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the register-file stream reader.
//   RfAddrWidth / RfDataWidth : default geometry of the 16x16 latch register file
//   rd_state_e                : read controller state encoding
package register_file_pkg;

  localparam int unsigned RfAddrWidth = 4;
  localparam int unsigned RfDataWidth = 16;

  typedef enum logic [1:0] {
    RdIdle  = 2'd0,
    RdRead  = 2'd1,
    RdDrain = 2'd2
  } rd_state_e;

endpackage

// File: rtl/register_file_stream_reader.sv
// Read-side controller for the latch register file. It takes a burst command
// (start address, length-1), walks the RF combinational read port and streams
// the words out over valid/ready, flagging the final word with out_last_o.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o    burst command handshake
//   cmd_addr_i, cmd_len_m1_i   first word address, burst length minus one
//   raddr_o, rdata_i           RF read port (rdata_i combinational from raddr_o)
//   out_valid_o/out_ready_i    output stream handshake
//   out_data_o, out_last_o     stream word and end-of-burst flag
//   busy_o                     burst in progress or output word still pending
//   stall_cnt_o                saturating count of stalled output cycles
//                              (only when RF_READER_STALL_CNT_EN is defined)
//
// Build option: define RF_READER_STALL_CNT_EN to add the stall counter port.
module register_file_stream_reader
  import register_file_pkg::*;
#(
  parameter int unsigned AddrWidth = RfAddrWidth,
  parameter int unsigned DataWidth = RfDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [AddrWidth-1:0] cmd_len_m1_i,
  output logic [AddrWidth-1:0] raddr_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o
`ifdef RF_READER_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt_o
`endif
);

  rd_state_e              state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [AddrWidth-1:0]   rem_q, rem_d;
  logic [AddrWidth-1:0]   raddr_q, raddr_d;
  logic                   out_valid_q, out_valid_d;
  logic [DataWidth-1:0]   out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_hs;
  logic                   cmd_accept;

  assign out_hs     = out_valid_q & out_ready_i;
  assign cmd_accept = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    cmd_ready_o = 1'b0;
    // Outside READ the read address parks on whatever was last driven so the
    // RF read mux does not toggle needlessly.
    raddr_o     = raddr_q;

    // A consumed word frees the output register unless refilled below.
    if (out_hs) out_valid_d = 1'b0;

    unique case (state_q)
      RdIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          rem_d   = cmd_len_m1_i;
          state_d = RdRead;
        end
      end
      RdRead: begin
        raddr_o = addr_q;
        // One-entry output register with pass-through ready: refill when
        // empty or when the current word is leaving this cycle.
        if (!out_valid_q || out_ready_i) begin
          out_data_d  = rdata_i;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == '0);
          addr_d      = addr_q + 1'b1;  // wraps mod NumWords
          rem_d       = rem_q - 1'b1;
          if (rem_q == '0) state_d = RdDrain;
        end
      end
      RdDrain: begin
        // The return to idle is the only exit; the next command is taken a
        // cycle later so it never overlaps the last-word handshake.
        if (out_hs && out_last_q) state_d = RdIdle;
      end
      default: state_d = RdIdle;
    endcase

    raddr_d = raddr_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RdIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      raddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      raddr_q     <= raddr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != RdIdle) | out_valid_q;

`ifdef RF_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cmd_accept) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_cmd_accept;
  assign unused_cmd_accept = cmd_accept;
`endif

endmodule

// File: tb/tb_register_file_stream_reader.sv
// Directed bench for register_file_stream_reader with a behavioural RF model.
module tb_register_file_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_addr;
  logic [3:0]  cmd_len_m1;
  logic [3:0]  raddr;
  logic [15:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef RF_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] mem [16];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  register_file_stream_reader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_m1_i (cmd_len_m1),
    .raddr_o      (raddr),
    .rdata_i      (rdata),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .busy_o       (busy)
`ifdef RF_READER_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full burst with out_ready held high; checks every word, last flag,
  // read-address sequence, and idle state after the final handshake.
  task automatic run_burst(input logic [3:0] a, input logic [3:0] l, input string tag);
    logic [3:0] ea;
    logic [3:0] er;
    out_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len_m1 = l;
    chk({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, " raddr first"}, 32'(raddr), 32'(a));
    chk({tag, " valid before first"}, 32'(out_valid), 32'd0);
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
`ifdef RF_READER_STALL_CNT_EN
    chk({tag, " stall cleared"}, 32'(stall_cnt), 32'd0);
`endif
    for (int k = 0; k <= int'(l); k++) begin
      tick();
      ea = a + 4'(k);
      er = (k < int'(l)) ? 4'(a + 4'(k) + 4'd1) : 4'(a + l);
      chk($sformatf("%s valid w%0d", tag, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s data w%0d", tag, k), 32'(out_data), 32'(mem[ea]));
      chk($sformatf("%s last w%0d", tag, k), 32'(out_last), 32'(k == int'(l)));
      chk($sformatf("%s raddr w%0d", tag, k), 32'(raddr), 32'(er));
    end
    tick();
    chk({tag, " valid after last"}, 32'(out_valid), 32'd0);
    chk({tag, " busy after last"}, 32'(busy), 32'd0);
    chk({tag, " cmd_ready after last"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(16'hC000 + i * 16'h0125);
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len_m1 = '0;
    out_ready  = 1'b0;

    // Reset values
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst raddr", 32'(raddr), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
`ifdef RF_READER_STALL_CNT_EN
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Plain burst mem[3..6]
    run_burst(4'd3, 4'd3, "t1");
    // 2. Wrap-around 15,0,1
    run_burst(4'd15, 4'd2, "t2");

    // 3. Full burst, odd words stall one cycle each
    cmd_valid  = 1'b1;
    cmd_addr   = 4'd0;
    cmd_len_m1 = 4'd15;
    out_ready  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t3 valid w%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t3 data w%0d", i), 32'(out_data), 32'(mem[i]));
      chk($sformatf("t3 last w%0d", i), 32'(out_last), 32'(i == 15));
      if (i % 2 == 1) begin
        out_ready = 1'b0;
        tick();
        chk($sformatf("t3 stall valid w%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("t3 stall data w%0d", i), 32'(out_data), 32'(mem[i]));
        chk($sformatf("t3 stall last w%0d", i), 32'(out_last), 32'(i == 15));
        out_ready = 1'b1;
      end
    end
    tick();
    chk("t3 valid after last", 32'(out_valid), 32'd0);
    chk("t3 busy after last", 32'(busy), 32'd0);
`ifdef RF_READER_STALL_CNT_EN
    chk("t3 stall_cnt", 32'(stall_cnt), 32'd8);
`endif

    // 4. Single word at 7
    run_burst(4'd7, 4'd0, "t4");

    // 5. cmd_valid held through a burst
    cmd_valid  = 1'b1;
    cmd_addr   = 4'd2;
    cmd_len_m1 = 4'd1;
    out_ready  = 1'b1;
    tick();
    cmd_addr   = 4'd9;
    cmd_len_m1 = 4'd0;
    chk("t5 cmd_ready read", 32'(cmd_ready), 32'd0);
    tick();
    chk("t5 data w0", 32'(out_data), 32'(mem[2]));
    chk("t5 cmd_ready w0", 32'(cmd_ready), 32'd0);
    tick();
    chk("t5 data w1", 32'(out_data), 32'(mem[3]));
    chk("t5 last w1", 32'(out_last), 32'd1);
    chk("t5 cmd_ready drain", 32'(cmd_ready), 32'd0);
    tick();
    chk("t5 valid idle", 32'(out_valid), 32'd0);
    chk("t5 cmd_ready idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t5 second accepted", 32'(cmd_ready), 32'd0);
    chk("t5 second raddr", 32'(raddr), 32'd9);
    tick();
    chk("t5 second data", 32'(out_data), 32'(mem[9]));
    chk("t5 second last", 32'(out_last), 32'd1);
    tick();
    chk("t5 second done", 32'(busy), 32'd0);

    // 6. Reset mid-burst after two words
    cmd_valid  = 1'b1;
    cmd_addr   = 4'd4;
    cmd_len_m1 = 4'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6 data w0", 32'(out_data), 32'(mem[4]));
    tick();
    chk("t6 data w1", 32'(out_data), 32'(mem[5]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst out_valid", 32'(out_valid), 32'd0);
    chk("t6 rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst last", 32'(out_last), 32'd0);
    chk("t6 rst raddr", 32'(raddr), 32'd0);
    chk("t6 rst data", 32'(out_data), 32'd0);
    tick();
    chk("t6 held valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    run_burst(4'd10, 4'd1, "t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
